router_pkt_receiver: RTL and testbench
======================================

Name: router_pkt_receiver

Overview:
- Receive-side deframer for the router byte-stream protocol. Connects to the router output (`dut_outp`/`outp_valid`).
- Parses the sa, da, len and crc header fields, forwards payload bytes downstream, and checks length and CRC.
- Reports a per-packet completion status and keeps saturating good/bad packet counters.
- It is the receiving end of the stream that the verification driver builds and transmits.

Parameters:
- MIN_PKT_LEN, 12, smallest legal len field value, in bytes.
- MAX_PKT_LEN, 2000, largest legal len field value, in bytes.
- CNT_W, 16, width of the packet counters.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx_data  in  8  stream byte.
- rx_valid  in  1  high for every byte of a packet, contiguously. A low cycle ends the packet.
- pkt_sa  out  8  source address of the last parsed packet.
- pkt_da  out  8  destination address of the last parsed packet.
- pkt_len  out  32  len field of the last parsed packet.
- pkt_crc  out  32  crc field of the last parsed packet.
- pl_data  out  8  payload byte.
- pl_valid  out  1  pl_data qualifier.
- pkt_done  out  1  one-cycle pulse when a packet finishes.
- pkt_ok  out  1  valid with pkt_done; 1 means no error.
- err_code  out  3  valid with pkt_done: 0 none, 1 crc mismatch, 2 len<MIN, 3 len>MAX, 4 length mismatch.
- good_cnt  out  CNT_W  packets with pkt_ok=1; saturates.
- bad_cnt  out  CNT_W  packets with pkt_ok=0; saturates.
- busy  out  1  high from the first sampled byte until pkt_done.

Behaviour:
- Wire format in arrival order:
  - sa, 1 byte.
  - da, 1 byte.
  - len, 4 bytes, LSB first.
  - crc, 4 bytes, LSB first.
  - payload, len−10 bytes.
- len counts all bytes, header included.
- CRC rule:
  - Computed value is the 8-bit wrap-around sum of the payload bytes, zero-extended to 32 bits.
  - The packet passes only if this equals the full 32-bit crc field.
- Reset (asynchronous, reset=0): every output is 0, the FSM goes to IDLE, and the accumulators and byte counter are cleared.
- FSM states: IDLE, SA, DA, LEN, CRC, PAYLOAD, DROP, DONE.
  - IDLE→DA: on rx_valid=1; the captured byte is sa.
  - DA→LEN: on the next valid byte (da).
  - LEN: 4 valid bytes, then → CRC.
  - Range check: evaluated on the cycle the 4th len byte is captured. If the length is out of range → DROP with err 2 or 3.
  - CRC: 4 valid bytes, then → PAYLOAD.
  - PAYLOAD: accumulates the sum and counts bytes.
  - End of packet: rx_valid=0 while in any non-IDLE state → DONE.
- Payload forwarding:
  - pl_data and pl_valid are registered, one cycle after the rx byte.
  - Forwarded only in PAYLOAD and only while the byte count is ≤ len.
  - No pl_valid in DROP.
- Length check:
  - Total bytes received ≠ len → err 4. This covers a truncated packet, and extra bytes, which are not forwarded.
  - A truncated packet ending during header states → err 4.
- Error priority: 2/3 > 4 > 1.
- DONE state:
  - Lasts one cycle; pkt_done=1 there, meaning the pulse follows the edge that sampled rx_valid=0.
  - Updates err_code and pkt_ok and increments exactly one counter; counters hold at all-ones.
  - Returns to IDLE.
- Header outputs: pkt_sa, pkt_da, pkt_len and pkt_crc update as the fields are captured and hold until the next packet overwrites them.
- busy:
  - Rises the cycle after the first byte.
  - Falls together with the pkt_done pulse.
- Back-to-back packets:
  - A minimum 1-cycle rx_valid low gap separates packets.
  - If rx_valid=1 during DONE, that byte is taken as the next sa, with no byte lost.
- Reset mid-packet: the packet is abandoned, with no pkt_done and no counter change. The next valid byte after release is sa.
- len wrap: byte counter is 32 bits. Any len > MAX_PKT_LEN is dropped before the counter can wrap.

Test Plan:
- Good packet.
  - Stimulus: sa=04, da=08, len=20 (14 00 00 00), crc=37 (37 00 00 00), payload 01..0A.
  - Response: pl_valid for 10 cycles with 01..0A; pkt_done with ok=1, err=0; good_cnt=1; pkt_sa=04, pkt_da=08, pkt_len=20.
- CRC error: same packet with crc=38 → all 10 payload bytes forwarded, pkt_ok=0, err=1, bad_cnt=1.
- Length range.
  - len=11 → no pl_valid, err=2.
  - len=2001 → no pl_valid, err=3.
  - Both cases: the bytes are consumed until rx_valid low.
- Length mismatch.
  - len=20 with only 19 bytes driven → err=4, 9 payload bytes forwarded.
  - len=20 with 22 bytes driven → err=4, only 10 payload bytes forwarded.
- Back-to-back: two good packets separated by a single idle cycle → two pkt_done pulses, good_cnt=2, correct header values for each.
- Reset mid-payload: reset low after the 5th payload byte, then a good packet → counters 0 after reset, then good_cnt=1, err=0.

Source files
------------

// File: rtl/router_pkt_receiver.sv
// router_pkt_receiver
//   Receive-side deframer for the router byte stream. Parses the sa/da/len/crc
//   header, forwards payload bytes, checks length and payload checksum, reports
//   a per-packet status pulse and keeps saturating good/bad packet counters.
//
// Ports
//   clk, reset           : clock (rising edge), asynchronous active-low reset
//   rx_data, rx_valid    : input byte stream; rx_valid low ends a packet
//   pkt_sa/da/len/crc    : header fields of the most recent packet
//   pl_data, pl_valid    : registered payload byte stream
//   pkt_done             : one-cycle completion pulse
//   pkt_ok, err_code     : completion status (0 none, 1 crc, 2 short len,
//                          3 long len, 4 length mismatch)
//   good_cnt, bad_cnt    : saturating packet counters
//   busy                 : packet in progress
module router_pkt_receiver #(
    parameter int unsigned MIN_PKT_LEN = 12,
    parameter int unsigned MAX_PKT_LEN = 2000,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic [7:0]       pkt_sa,
    output logic [7:0]       pkt_da,
    output logic [31:0]      pkt_len,
    output logic [31:0]      pkt_crc,
    output logic [7:0]       pl_data,
    output logic             pl_valid,
    output logic             pkt_done,
    output logic             pkt_ok,
    output logic [2:0]       err_code,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] bad_cnt,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_SA, S_DA, S_LEN, S_CRC, S_PAYLOAD, S_DROP, S_DONE
    } state_t;

    state_t r_state, w_next;

    logic [7:0]       r_sa, r_da, r_sum, r_pl_data;
    logic [31:0]      r_len, r_crc, r_cnt;
    logic [1:0]       r_idx;
    logic [2:0]       r_rng_err, r_err;
    logic             r_pl_valid, r_ok;
    logic [CNT_W-1:0] r_good, r_bad;

    logic [31:0]      w_len_full;
    logic             w_len_lo, w_len_hi, w_start, w_fwd;
    logic [2:0]       w_err;

    // Full length as it will look once the 4th (MSB) len byte lands.
    assign w_len_full = {rx_data, r_len[23:0]};
    assign w_len_lo   = w_len_full < MIN_PKT_LEN;
    assign w_len_hi   = w_len_full > MAX_PKT_LEN;
    // A byte in DONE starts the next packet just like one in IDLE.
    assign w_start    = rx_valid && (r_state == S_IDLE || r_state == S_DONE);
    // Bytes beyond len are consumed but not forwarded.
    assign w_fwd      = (r_state == S_PAYLOAD) && rx_valid && (r_cnt + 32'd1 <= r_len);

    // Status for the packet ending now; priority range > length > crc.
    always_comb begin
        w_err = 3'd0;
        if (r_state == S_DROP)
            w_err = r_rng_err;
        else if (r_state != S_PAYLOAD || r_cnt != r_len)
            w_err = 3'd4;
        else if ({24'd0, r_sum} != r_crc)
            w_err = 3'd1;
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (rx_valid) w_next = S_DA;
            S_SA:      w_next = S_IDLE;  // sa is taken on the IDLE/DONE exit byte
            S_DA:      w_next = rx_valid ? S_LEN : S_DONE;
            S_LEN: begin
                if (!rx_valid)          w_next = S_DONE;
                else if (r_idx == 2'd3) w_next = (w_len_lo || w_len_hi) ? S_DROP : S_CRC;
            end
            S_CRC: begin
                if (!rx_valid)          w_next = S_DONE;
                else if (r_idx == 2'd3) w_next = S_PAYLOAD;
            end
            S_PAYLOAD: if (!rx_valid) w_next = S_DONE;
            S_DROP:    if (!rx_valid) w_next = S_DONE;
            S_DONE:    w_next = rx_valid ? S_DA : S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        pkt_done = (r_state == S_DONE);
        busy     = (r_state != S_IDLE) && (r_state != S_DONE);
    end

    // Datapath: header capture, byte count, checksum, status and counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sa       <= '0;
            r_da       <= '0;
            r_len      <= '0;
            r_crc      <= '0;
            r_cnt      <= '0;
            r_sum      <= '0;
            r_idx      <= '0;
            r_rng_err  <= '0;
            r_err      <= '0;
            r_ok       <= 1'b0;
            r_pl_data  <= '0;
            r_pl_valid <= 1'b0;
            r_good     <= '0;
            r_bad      <= '0;
        end else begin
            r_pl_valid <= w_fwd;
            if (w_fwd) r_pl_data <= rx_data;

            if (w_start) begin
                r_sa      <= rx_data;
                r_cnt     <= 32'd1;
                r_sum     <= '0;
                r_idx     <= '0;
                r_rng_err <= '0;
            end else if (rx_valid) begin
                case (r_state)
                    S_DA: begin
                        r_da  <= rx_data;
                        r_cnt <= r_cnt + 32'd1;
                        r_idx <= '0;
                    end
                    S_LEN: begin
                        r_len[{r_idx, 3'b000} +: 8] <= rx_data;
                        r_cnt <= r_cnt + 32'd1;
                        r_idx <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            if (w_len_lo)      r_rng_err <= 3'd2;
                            else if (w_len_hi) r_rng_err <= 3'd3;
                        end
                    end
                    S_CRC: begin
                        r_crc[{r_idx, 3'b000} +: 8] <= rx_data;
                        r_cnt <= r_cnt + 32'd1;
                        r_idx <= r_idx + 2'd1;
                    end
                    S_PAYLOAD: begin
                        r_cnt <= r_cnt + 32'd1;
                        if (w_fwd) r_sum <= r_sum + rx_data;
                    end
                    default: ;
                endcase
            end

            // Status and counters change on entry to DONE so they are
            // already valid while pkt_done is high.
            if (w_next == S_DONE) begin
                r_err <= w_err;
                r_ok  <= (w_err == 3'd0);
                if (w_err == 3'd0) begin
                    if (r_good != {CNT_W{1'b1}}) r_good <= r_good + 1'b1;
                end else begin
                    if (r_bad != {CNT_W{1'b1}}) r_bad <= r_bad + 1'b1;
                end
            end
        end
    end

    assign pkt_sa   = r_sa;
    assign pkt_da   = r_da;
    assign pkt_len  = r_len;
    assign pkt_crc  = r_crc;
    assign pl_data  = r_pl_data;
    assign pl_valid = r_pl_valid;
    assign pkt_ok   = r_ok;
    assign err_code = r_err;
    assign good_cnt = r_good;
    assign bad_cnt  = r_bad;

endmodule

// File: tb/tb_router_pkt_receiver.sv
module tb_router_pkt_receiver;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  pkt_sa, pkt_da, pl_data;
    logic [31:0] pkt_len, pkt_crc;
    logic        pl_valid, pkt_done, pkt_ok, busy;
    logic [2:0]  err_code;
    logic [15:0] good_cnt, bad_cnt;

    always #5 clk = ~clk;

    router_pkt_receiver dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .pkt_sa(pkt_sa), .pkt_da(pkt_da), .pkt_len(pkt_len), .pkt_crc(pkt_crc),
        .pl_data(pl_data), .pl_valid(pl_valid), .pkt_done(pkt_done),
        .pkt_ok(pkt_ok), .err_code(err_code), .good_cnt(good_cnt),
        .bad_cnt(bad_cnt), .busy(busy)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // Monitor: payload bytes and a snapshot of status at every pkt_done.
    logic [7:0]  pl_q[$];
    logic [2:0]  d_err[$];
    logic        d_ok[$];
    logic [7:0]  d_sa[$], d_da[$];
    logic [31:0] d_len[$];
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (pl_valid) pl_q.push_back(pl_data);
        if (pkt_done) begin
            done_cnt++;
            d_err.push_back(err_code);
            d_ok.push_back(pkt_ok);
            d_sa.push_back(pkt_sa);
            d_da.push_back(pkt_da);
            d_len.push_back(pkt_len);
        end
    end

    logic [7:0] pk[$];

    // Header plus npl payload bytes counting up from first.
    task automatic build(input logic [7:0] sa, input logic [7:0] da,
                         input logic [31:0] len, input logic [31:0] crc,
                         input int npl, input int first);
        pk.delete();
        pk.push_back(sa);
        pk.push_back(da);
        for (int i = 0; i < 4; i++) pk.push_back(len[8*i +: 8]);
        for (int i = 0; i < 4; i++) pk.push_back(crc[8*i +: 8]);
        for (int i = 0; i < npl; i++) pk.push_back(8'(first + i));
    endtask

    task automatic send_bytes();
        foreach (pk[i]) begin
            @(posedge clk); #1;
            rx_valid = 1'b1;
            rx_data  = pk[i];
        end
    endtask

    task automatic end_pkt();
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic wait_done(input int tgt);
        for (int i = 0; i < 20; i++) begin
            if (done_cnt >= tgt) break;
            @(posedge clk);
        end
        #1;
        chk("done_count", done_cnt, tgt);
    endtask

    int base;

    initial begin
        reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_good", good_cnt, 0);
        chk("rst_bad", bad_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", pkt_done, 0);
        chk("rst_plv", pl_valid, 0);
        chk("rst_err", err_code, 0);
        chk("rst_len", pkt_len, 0);
        @(posedge clk); #1 reset = 1'b1;

        // Good packet: payload 1..10 sums to 0x37
        pl_q.delete();
        build(8'h04, 8'h08, 20, 32'h37, 10, 1);
        send_bytes();
        chk("busy_mid", busy, 1);
        end_pkt();
        wait_done(1);
        chk("good_npl", pl_q.size(), 10);
        for (int i = 0; i < 10 && i < pl_q.size(); i++) chk("good_pl", pl_q[i], i + 1);
        chk("good_err", d_err[0], 0);
        chk("good_ok", d_ok[0], 1);
        chk("good_gcnt", good_cnt, 1);
        chk("good_bcnt", bad_cnt, 0);
        chk("good_sa", pkt_sa, 8'h04);
        chk("good_da", pkt_da, 8'h08);
        chk("good_len", pkt_len, 20);
        chk("good_crc", pkt_crc, 32'h37);
        chk("good_busy_end", busy, 0);

        // CRC mismatch
        pl_q.delete();
        build(8'h04, 8'h08, 20, 32'h38, 10, 1);
        send_bytes(); end_pkt(); wait_done(2);
        chk("crc_npl", pl_q.size(), 10);
        chk("crc_err", d_err[1], 1);
        chk("crc_ok", d_ok[1], 0);
        chk("crc_bcnt", bad_cnt, 1);
        chk("crc_gcnt", good_cnt, 1);

        // len below minimum
        pl_q.delete();
        build(8'h04, 8'h08, 11, 32'h0, 1, 1);
        send_bytes(); end_pkt(); wait_done(3);
        chk("short_npl", pl_q.size(), 0);
        chk("short_err", d_err[2], 2);
        chk("short_bcnt", bad_cnt, 2);
        chk("short_len", pkt_len, 11);

        // len above maximum
        pl_q.delete();
        build(8'h04, 8'h08, 2001, 32'h0, 5, 1);
        send_bytes(); end_pkt(); wait_done(4);
        chk("long_npl", pl_q.size(), 0);
        chk("long_err", d_err[3], 3);
        chk("long_bcnt", bad_cnt, 3);

        // Truncated: 19 bytes for len 20
        pl_q.delete();
        build(8'h04, 8'h08, 20, 32'h37, 9, 1);
        send_bytes(); end_pkt(); wait_done(5);
        chk("trunc_npl", pl_q.size(), 9);
        chk("trunc_err", d_err[4], 4);
        chk("trunc_bcnt", bad_cnt, 4);

        // Overlong: 22 bytes for len 20, only 10 forwarded
        pl_q.delete();
        build(8'h04, 8'h08, 20, 32'h37, 12, 1);
        send_bytes(); end_pkt(); wait_done(6);
        chk("over_npl", pl_q.size(), 10);
        if (pl_q.size() > 0) chk("over_last", pl_q[pl_q.size()-1], 10);
        chk("over_err", d_err[5], 4);
        chk("over_bcnt", bad_cnt, 5);
        chk("over_gcnt", good_cnt, 1);

        // Back-to-back with a single idle cycle; second payload 5+6+7=0x12
        base = done_cnt;
        build(8'h11, 8'h22, 20, 32'h37, 10, 1);
        send_bytes(); end_pkt();
        build(8'h33, 8'h44, 13, 32'h12, 3, 5);
        send_bytes(); end_pkt();
        wait_done(base + 2);
        if (d_sa.size() >= base + 2) begin
            chk("b2b_sa0", d_sa[base], 8'h11);
            chk("b2b_da0", d_da[base], 8'h22);
            chk("b2b_len0", d_len[base], 20);
            chk("b2b_err0", d_err[base], 0);
            chk("b2b_sa1", d_sa[base+1], 8'h33);
            chk("b2b_da1", d_da[base+1], 8'h44);
            chk("b2b_len1", d_len[base+1], 13);
            chk("b2b_err1", d_err[base+1], 0);
        end
        chk("b2b_gcnt", good_cnt, 3);

        // Reset after the 5th payload byte, then a good packet
        base = done_cnt;
        build(8'h04, 8'h08, 20, 32'h37, 5, 1);
        send_bytes();
        @(posedge clk); #1;
        reset = 1'b0; rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_rst_gcnt", good_cnt, 0);
        chk("mid_rst_bcnt", bad_cnt, 0);
        chk("mid_rst_busy", busy, 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_rst_nodone", done_cnt, base);
        build(8'h55, 8'h66, 20, 32'h37, 10, 1);
        send_bytes(); end_pkt(); wait_done(base + 1);
        if (d_err.size() > base) chk("post_rst_err", d_err[base], 0);
        chk("post_rst_gcnt", good_cnt, 1);
        chk("post_rst_bcnt", bad_cnt, 0);
        chk("post_rst_sa", pkt_sa, 8'h55);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
